// File: rtl/mips_defs.sv
// mips_defs: shared state encodings, opcodes and control field codes for the multicycle MIPS
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the opcodes this controller knows how to sequence
    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer driving the multicycle MIPS datapath and counting retired instructions
module multicycle_control
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state_q, state_d;
    logic   retire;

    assign state  = state_q;
    assign retire = state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP};

    // State register; reset wins over every transition
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Retired-instruction counter, bumped on the edge leaving a final state
    always_ff @(posedge clock) begin
        if (reset)       retired <= '0;
        else if (retire) retired <= retired + CNT_W'(1);
    end

    // Next-state logic; opcode matters only in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode from state alone, all held low while reset is asserted
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    IRWrite  = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_ALU;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                    illegal = !is_legal(opcode);
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven scoreboard bench for the multicycle sequencer
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]       st;
        logic             cst;
        logic [16:0]      ctl;
        logic [CNT_W-1:0] ret;
        logic             cret;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        int          n;
        logic [19:0] sts;
        bit          ret;
    } vec_t;

    exp_t             sb[$];
    vec_t             tbl[7];
    logic [CNT_W-1:0] ret_m = '0;
    int               n_cmp = 0;
    int               n_bad = 0;

    // Control word expected in each state, bits {PCWrite..PCSource}
    function automatic logic [15:0] model(input logic [3:0] s);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] srcb, aop, psrc;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, psrc} = '0;
        case (s)
            4'd0: begin mr = 1; irw = 1; srcb = 2'b01; pcw = 1; psrc = 2'b00; end
            4'd1: srcb = 2'b11;
            4'd2: begin sa = 1; srcb = 2'b10; end
            4'd3: begin mr = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mw = 1; iord = 1; end
            4'd6: begin sa = 1; aop = 2'b10; end
            4'd7: begin rw = 1; rd = 1; end
            4'd8: begin sa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            4'd9: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, psrc};
    endfunction

    function automatic logic known_op(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010;
    endfunction

    task automatic check();
        exp_t e;
        logic [16:0] act;
        e = sb.pop_front();
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
        if (e.cst) begin
            n_cmp++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL state: got %0d want %0d at %0t", state, e.st, $time);
            end
        end
        n_cmp++;
        if (act !== e.ctl) begin
            n_bad++;
            $display("FAIL ctrl(st=%0d): got %h want %h at %0t", e.st, act, e.ctl, $time);
        end
        if (e.cret) begin
            n_cmp++;
            if (retired !== e.ret) begin
                n_bad++;
                $display("FAIL retired: got %0d want %0d at %0t", retired, e.ret, $time);
            end
        end
    endtask

    // One clock cycle: drive, queue the expectation, compare mid-cycle, advance past the edge
    task automatic step(input logic [5:0] op, input logic rst, input logic [3:0] est,
                        input bit cst, input bit cret);
        exp_t e;
        opcode = op;
        reset  = rst;
        e.st   = est;
        e.cst  = cst;
        e.ctl  = rst ? '0 : {model(est), est == 4'd1 && !known_op(op)};
        e.ret  = ret_m;
        e.cret = cret;
        sb.push_back(e);
        @(negedge clock);
        check();
        @(posedge clock);
        #1;
        if (rst) ret_m = '0;
    endtask

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic run_instr(input int i);
        logic [3:0] s;
        for (int k = 0; k < tbl[i].n; k++) begin
            s = tbl[i].sts[4*k +: 4];
            step((s == 4'd1 || s == 4'd2) ? tbl[i].op : rnd_op(), 1'b0, s, 1'b1, 1'b1);
        end
        if (tbl[i].ret) ret_m = ret_m + 1'b1;
    endtask

    initial begin
        tbl[0] = '{6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}, 1'b1};
        tbl[1] = '{6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1};
        tbl[2] = '{6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b1};
        tbl[3] = '{6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}, 1'b1};
        tbl[4] = '{6'b000010, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}, 1'b1};
        tbl[5] = '{6'b111111, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b0};
        tbl[6] = '{6'b001000, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}, 1'b0};

        reset  = 1'b1;
        opcode = '0;
        @(posedge clock);
        #1;
        ret_m = '0;
        step(6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
        step(6'h23, 1'b1, 4'd0, 1'b1, 1'b1);

        for (int i = 0; i < 7; i++) run_instr(i);

        // Reset during MEMRD of a lw: no MemRead/RegWrite, back to FETCH, count cleared
        step(rnd_op(), 1'b0, 4'd0, 1'b1, 1'b1);
        step(6'b100011, 1'b0, 4'd1, 1'b1, 1'b1);
        step(6'b100011, 1'b0, 4'd2, 1'b1, 1'b1);
        step(6'b100011, 1'b1, 4'd3, 1'b1, 1'b1);
        run_instr(0);

        // Reset during DECODE of an illegal opcode suppresses the illegal pulse
        step(rnd_op(), 1'b0, 4'd0, 1'b1, 1'b1);
        step(6'b111111, 1'b1, 4'd1, 1'b1, 1'b1);
        run_instr(3);
        run_instr(4);

        // Counter wrap: 16 R-type instructions from zero return to zero
        step(6'h00, 1'b1, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) run_instr(0);
        @(negedge clock);
        n_cmp++;
        if (retired !== 4'd0) begin
            n_bad++;
            $display("FAIL wrap: got %0d want 0", retired);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
